// File: rtl/multiplier_datapath_if.sv
// ----------------------------------------------------------------------------
// multiplier_datapath_if
// Strobe/data bundle between the add-shift multiplier control FSM and its
// register/arithmetic datapath.
//
// Signals:
//   LD_XA    load the adder result into {X, A}
//   LD_B     load Din into B
//   Shift_EN arithmetic right shift of {X, A, B}
//   Cnt_EN   increment the iteration counter
//   Clr_XA   clear X, A and the counter
//   SUB_ADD  adder mode (0 = A + Din, 1 = A - Din)
//   Din      8-bit two's complement operand
//   M        current multiplier bit (B[0])
//   count    3-bit iteration counter
//   X        sign-extension bit
//   Aval     register A
//   Bval     register B
//
// Modports: master = control FSM / stimulus side, slave = datapath.
// ----------------------------------------------------------------------------
interface multiplier_datapath_if;
  logic       LD_XA;
  logic       LD_B;
  logic       Shift_EN;
  logic       Cnt_EN;
  logic       Clr_XA;
  logic       SUB_ADD;
  logic [7:0] Din;
  logic       M;
  logic [2:0] count;
  logic       X;
  logic [7:0] Aval;
  logic [7:0] Bval;

  modport master (
    output LD_XA, LD_B, Shift_EN, Cnt_EN, Clr_XA, SUB_ADD, Din,
    input  M, count, X, Aval, Bval
  );

  modport slave (
    input  LD_XA, LD_B, Shift_EN, Cnt_EN, Clr_XA, SUB_ADD, Din,
    output M, count, X, Aval, Bval
  );
endinterface

// File: rtl/multiplier_datapath.sv
// ----------------------------------------------------------------------------
// multiplier_datapath
// Register and arithmetic half of the 8-bit signed add-shift multiplier.
// Holds the 17-bit product register {X, A, B} and the 3-bit iteration counter,
// and executes the per-cycle strobes issued by the control FSM.
//
// Ports:
//   Clk    system clock, all state updates on the rising edge
//   Reset  synchronous, active-high reset (clears every register)
//   bus    multiplier_datapath_if.slave: strobes, Din, SUB_ADD in;
//          M, count, X, Aval, Bval out (all direct register outputs)
//
// Build option:
//   MULT_DP_CNT_SAT_EN  defined: count saturates at 7.
//                       undefined: count wraps 7 -> 0.
// ----------------------------------------------------------------------------
module multiplier_datapath (
  input  logic                  Clk,
  input  logic                  Reset,
  multiplier_datapath_if.slave  bus
);

  logic              r_x;
  logic        [7:0] r_a;
  logic        [7:0] r_b;
  logic        [2:0] r_count;

  logic signed [8:0] w_a_ext;
  logic signed [8:0] w_din_ext;
  logic signed [8:0] w_cin;
  logic signed [8:0] w_sum;
  logic              w_shift;

  // Counter increment with the end-of-range behaviour chosen at build time.
  function automatic logic [2:0] f_cnt_inc(input logic [2:0] c);
`ifdef MULT_DP_CNT_SAT_EN
    return (c == 3'd7) ? c : c + 3'd1;
`else
    return c + 3'd1;
`endif
  endfunction

  // 9-bit sign-extended add/subtract; subtract is invert-and-carry-in.
  assign w_a_ext   = $signed({r_a[7], r_a});
  assign w_din_ext = $signed({bus.Din[7], bus.Din}) ^ $signed({9{bus.SUB_ADD}});
  assign w_cin     = $signed({8'd0, bus.SUB_ADD});
  assign w_sum     = w_a_ext + w_din_ext + w_cin;

  // The 17-bit register only ever shifts as a whole: any load or clear in the
  // same cycle suppresses the shift for all of {X, A, B}.
  assign w_shift = bus.Shift_EN & ~bus.LD_XA & ~bus.LD_B & ~bus.Clr_XA;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x     <= 1'b0;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_count <= 3'd0;
    end else begin
      if (bus.Clr_XA) begin
        r_x <= 1'b0;
        r_a <= 8'h00;
      end else if (bus.LD_XA) begin
        r_x <= w_sum[8];
        r_a <= w_sum[7:0];
      end else if (w_shift) begin
        r_a <= {r_x, r_a[7:1]};
      end

      if (bus.LD_B) begin
        r_b <= bus.Din;
      end else if (w_shift) begin
        r_b <= {r_a[0], r_b[7:1]};
      end

      if (bus.Clr_XA) begin
        r_count <= 3'd0;
      end else if (bus.Cnt_EN) begin
        r_count <= f_cnt_inc(r_count);
      end
    end
  end

  assign bus.M     = r_b[0];
  assign bus.X     = r_x;
  assign bus.Aval  = r_a;
  assign bus.Bval  = r_b;
  assign bus.count = r_count;

endmodule

// File: doc/multiplier_datapath.md
# multiplier_datapath

- Register-and-arithmetic half of the 8-bit signed add-shift multiplier.
- Executes the per-cycle control strobes issued by the multiplier control FSM: load, clear, add/subtract and arithmetic shift.
- Returns the multiplier LSB `M` and the iteration `count` that the FSM consumes.
- Holds the 17-bit product register {X, A, B} and drives its contents to the display/hex logic.

## Interface
Parameters: none (width fixed at 8).

- `Clk` input 1: single system clock; all state updates on its rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `LD_XA` input 1: load the adder result into {X, A}.
- `LD_B` input 1: load `Din` into B (the multiplier).
- `Shift_EN` input 1: arithmetic right shift of {X, A, B} by one.
- `Cnt_EN` input 1: increment the iteration counter.
- `Clr_XA` input 1: clear X, A and the counter.
- `SUB_ADD` input 1: adder mode; 0 = A + Din, 1 = A − Din.
- `Din` input 8: multiplicand / load operand (switches), two's complement.
- `M` output 1: B[0]; the current multiplier bit.
- `count` output 3: iteration counter.
- `X` output 1: sign-extension bit.
- `Aval` output 8: register A.
- `Bval` output 8: register B.

## Operation
- Adder: 9-bit two's complement. Sum = {A[7],A} + ({Din[7],Din} XOR {9{SUB_ADD}}) + SUB_ADD. The sum is combinational and is written only on `LD_XA`.
- On `LD_XA`: X ← sum[8], A ← sum[7:0]. The 9-bit sign extension guarantees no loss of the sign. No overflow output.
- On `Shift_EN`:
  - X unchanged.
  - A ← {X, A[7:1]}.
  - B ← {A[0], B[7:1]}.
- On `LD_B`: B ← Din.
- On `Clr_XA`: X ← 0, A ← 0, count ← 0.
- On `Cnt_EN`: count ← count + 1 (end-of-range behaviour: see Configuration).
- Priority for X/A: Reset > Clr_XA > LD_XA > Shift_EN > hold.
- Priority for B: Reset > LD_B > Shift_EN > hold.
- `LD_XA` and `Shift_EN` in the same cycle: the load wins and the shift is suppressed for all of {X, A, B}. The 17-bit register never shifts partially.
- `LD_B` and `Shift_EN` in the same cycle: B loads Din. X/A follow their own priority; the shift into them is still suppressed.
- `Cnt_EN` is independent of the data strobes. It may coincide with any of them except `Clr_XA`, which wins.
- No strobes asserted: all registers hold.

## Timing
- Reset values: X = 0, A = 0x00, B = 0x00, count = 0, M = 0.
- Reset takes effect on the first rising edge with `Reset` = 1, including mid-multiply. It overrides any strobe in that cycle.
- Strobe-to-register latency is 1 cycle. A strobe sampled at edge n is visible on the outputs after edge n.
- `M`, `X`, `Aval`, `Bval` and `count` are direct register outputs (M = B[0]), with no combinational path from the inputs. The FSM may therefore branch on `M` in the cycle after a shift without a combinational loop.
- `Din` and `SUB_ADD` need only be stable at the edge where `LD_XA` or `LD_B` is sampled.

## Configuration
- `MULT_DP_CNT_SAT_EN` defined: count saturates at 7; `Cnt_EN` at 7 leaves 7.
- Not defined: count wraps 7 → 0 (plain 3-bit modulo).
- Only `Clr_XA` and `Reset` clear count in both builds.

## Test plan
- **Reset:** assert `Reset` for 1 cycle with all strobes high → X = 0, A = 0x00, B = 0x00, count = 0, M = 0.
- **Load/add/shift:**
  - `LD_B`, Din = 0x07 → B = 0x07, M = 1.
  - `Clr_XA`, then `LD_XA` with SUB_ADD = 0, Din = 0xFD → X = 1, A = 0xFD.
  - `Shift_EN` → X = 1, A = 0xFE, B = 0x83, M = 1.
- **Subtract:** A = 0x00, X = 0; `LD_XA` with SUB_ADD = 1, Din = 0x01 → X = 1, A = 0xFF.
- **Full 7 × −3:**
  - Setup: B = 0x07, Din = 0xFD.
  - Driven sequence: 8 iterations of (add if M, shift, Cnt_EN); the last iteration with M = 1 uses subtract.
  - Expected: {A, B} = 0xFFEB (−21), X = 1.
- **Simultaneous/priority:**
  - `LD_XA` + `Shift_EN` with A = 0x10, B = 0x55, Din = 0x01 → A = 0x11, B = 0x55 (no shift).
  - `Clr_XA` + `Cnt_EN` at count = 3 → count = 0.
- **Counter end:** 8 `Cnt_EN` pulses from 0 → count = 0 with the macro undefined, 7 with `MULT_DP_CNT_SAT_EN`. `Reset` mid-count → count = 0 next cycle.
